// File: rtl/fetch_decode.sv
// Instruction fetch and field-split stage of the 16-bit core.
// Owns the fetch PC and runs a req/ack read handshake to instruction memory.
// It holds the fetched word and splits it into the immediate fields for the
// immediate generator. Taken branches and jumps redirect the PC, using the
// extended immediate that the generator returns.
// Optional: define CUPS_FETCH_PERF_EN to add saturating fetch/flush counters.
module fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic        redirect_kind,
    input  logic [15:0] imm,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [3:0]  tb,
    output logic [7:0]  tc,
    output logic [11:0] td,
    output logic [1:0]  B,
    output logic        sz
`ifdef CUPS_FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StFlush} state_e;

    state_e      state_q, state_d;
    logic [15:0] fpc_q, fpc_d;        // address of the next/outstanding fetch
    logic [15:0] pend_q, pend_d;      // redirect target waiting for a discarded ack
    logic [15:0] issued_q, issued_d;  // pc of the last consumed instruction
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;        // pc of the held instruction
    logic        valid_q, valid_d;
    logic [1:0]  b_q, b_d;
    logic [1:0]  b_dec;
    logic [15:0] target;
    logic        consume;

    // Redirect target: branches are issued_pc-relative, jumps keep the page bits.
    always_comb begin
        target = 16'h0000;
        if (redirect_kind) begin
            target = {issued_q[15:12], imm[11:0]};
        end else begin
            target = issued_q + 16'd1 + imm;
        end
    end

    // Immediate type selector decoded from the incoming word's opcode nibble.
    always_comb begin
        b_dec = 2'b11;
        unique casez (imem_data[15:12])
            4'b0???: b_dec = 2'b00;
            4'b10??: b_dec = 2'b01;
            4'b1100: b_dec = 2'b10;
            default: b_dec = 2'b11;
        endcase
    end

    assign consume = valid_q & ~stall;

    // Next-state logic for the fetch FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        pend_d   = pend_q;
        issued_d = issued_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        b_d      = b_q;
        case (state_q)
            StFetch: begin
                if (redirect) begin
                    if (imem_ack) begin
                        // Data from the old address is dropped; refetch next cycle.
                        fpc_d = target;
                    end else begin
                        // Request stays on the bus until its ack arrives.
                        pend_d  = target;
                        state_d = StFlush;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_data;
                    ipc_d   = fpc_q;
                    fpc_d   = fpc_q + PC_STEP;
                    valid_d = 1'b1;
                    b_d     = b_dec;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect) begin
                    // Held instruction is squashed, so issued_pc is not updated.
                    fpc_d   = target;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (consume) begin
                    issued_d = ipc_q;
                    valid_d  = 1'b0;
                    state_d  = StFetch;
                end
            end
            StFlush: begin
                if (imem_ack) begin
                    fpc_d   = redirect ? target : pend_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            fpc_q    <= RESET_PC;
            pend_q   <= RESET_PC;
            issued_q <= RESET_PC;
            instr_q  <= 16'h0000;
            ipc_q    <= RESET_PC;
            valid_q  <= 1'b0;
            b_q      <= 2'b11;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            pend_q   <= pend_d;
            issued_q <= issued_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            b_q      <= b_d;
        end
    end

    // Request is masked during reset so an abandoned fetch drops immediately.
    assign imem_req    = ~reset & (state_q != StHold);
    assign imem_addr   = fpc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = ipc_q;
    assign tb          = instr_q[3:0];
    assign tc          = instr_q[7:0];
    assign td          = instr_q[11:0];
    assign sz          = instr_q[12];
    assign B           = b_q;

`ifdef CUPS_FETCH_PERF_EN
    logic [15:0] fcnt_q, lcnt_q;
    logic        fetch_evt;

    assign fetch_evt = (state_q == StHold) & consume & ~redirect;

    // Saturating counters of consumed instructions and accepted redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q <= 16'h0000;
            lcnt_q <= 16'h0000;
        end else begin
            if (fetch_evt && fcnt_q != 16'hFFFF) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
            if (redirect && lcnt_q != 16'hFFFF) begin
                lcnt_q <= lcnt_q + 16'd1;
            end
        end
    end

    assign fetch_count = fcnt_q;
    assign flush_count = lcnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic        redirect_kind;
    logic [15:0] imm;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [3:0]  tb;
    logic [7:0]  tc;
    logic [11:0] td;
    logic [1:0]  b_out;
    logic        sz;
`ifdef CUPS_FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_decode #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'd1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_kind (redirect_kind),
        .imm           (imm),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
        .tb            (tb),
        .tc            (tc),
        .td            (td),
        .B             (b_out),
        .sz            (sz)
`ifdef CUPS_FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
`endif
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        imem_ack      = 1'b0;
        imem_data     = 16'h0000;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_kind = 1'b0;
        imm           = 16'h0000;
    endtask

    // Type selector from the opcode nibble, by numeric range.
    function automatic logic [1:0] exp_b(input logic [15:0] w);
        int top;
        top = int'(w[15:12]);
        if (top < 8) return 2'b00;
        if (top < 12) return 2'b01;
        if (top == 12) return 2'b10;
        return 2'b11;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h want=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h want=0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h want=0000", instr); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h want=0000", pc); end
        checks++; if (b_out !== 2'b11) begin failures++; $display("FAIL reset_B got=%b want=11", b_out); end
        checks++; if ({tb, tc, td, sz} !== 25'd0) begin failures++; $display("FAIL reset_fields got=%h want=0", {tb, tc, td, sz}); end
`ifdef CUPS_FETCH_PERF_EN
        checks++; if ({fetch_count, flush_count} !== 32'd0) begin failures++; $display("FAIL reset_counters got=%h want=0", {fetch_count, flush_count}); end
`endif
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL post_reset_req got=%0h want=1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL post_reset_addr got=%h want=0000", imem_addr); end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL wait_req got=%0h/%h want=1/0000", imem_req, imem_addr); end
        end
        imem_ack = 1'b1; imem_data = 16'h1234;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h want=1", instr_valid); end
        checks++; if (instr !== 16'h1234) begin failures++; $display("FAIL basic_instr got=%h want=1234", instr); end
        checks++; if (b_out !== 2'b00) begin failures++; $display("FAIL basic_B got=%b want=00", b_out); end
        checks++; if (tb !== 4'h4) begin failures++; $display("FAIL basic_tb got=%h want=4", tb); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_hold_req got=%0h want=0", imem_req); end
        cyc();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0h want=0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin failures++; $display("FAIL basic_next got=%0h/%h want=1/0001", imem_req, imem_addr); end
    endtask

    task automatic test_branch;
        // Jump to 0x0010 coincident with an ack; issued_pc is 0x0000.
        redirect = 1'b1; redirect_kind = 1'b1; imm = 16'h0010; imem_ack = 1'b1; imem_data = 16'hDEAD;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0010) begin failures++; $display("FAIL br_setup got=%0h/%h want=0/0010", instr_valid, imem_addr); end
        imem_ack = 1'b1; imem_data = 16'h8AF0;
        cyc();
        clear_inputs();
        checks++; if (b_out !== 2'b01 || tc !== 8'hF0) begin failures++; $display("FAIL br_fields got=%b/%h want=01/f0", b_out, tc); end
        checks++; if (pc !== 16'h0010) begin failures++; $display("FAIL br_pc got=%h want=0010", pc); end
        cyc();
        redirect = 1'b1; redirect_kind = 1'b0; imm = 16'hFFF0;
        cyc();
        clear_inputs();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0011) begin failures++; $display("FAIL br_flush_addr got=%0h/%h want=1/0011", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = 16'h7777;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0001) begin failures++; $display("FAIL br_target got=%0h/%h want=0/0001", instr_valid, imem_addr); end
    endtask

    task automatic test_jump;
        // Branch from issued_pc 0x0010 to 0x5000.
        redirect = 1'b1; redirect_kind = 1'b0; imm = 16'h4FEF; imem_ack = 1'b1;
        cyc();
        clear_inputs();
        checks++; if (imem_addr !== 16'h5000) begin failures++; $display("FAIL jp_setup got=%h want=5000", imem_addr); end
        imem_ack = 1'b1; imem_data = 16'hC123;
        cyc();
        clear_inputs();
        checks++; if (b_out !== 2'b10 || td !== 12'h123 || sz !== 1'b0) begin failures++; $display("FAIL jp_fields got=%b/%h/%0h want=10/123/0", b_out, td, sz); end
        checks++; if (pc !== 16'h5000) begin failures++; $display("FAIL jp_pc got=%h want=5000", pc); end
        cyc();
        redirect = 1'b1; redirect_kind = 1'b1; imm = 16'hF123;
        cyc();
        clear_inputs();
        imem_ack = 1'b1;
        cyc();
        clear_inputs();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h5123) begin failures++; $display("FAIL jp_target got=%0h/%h want=1/5123", imem_req, imem_addr); end
    endtask

    task automatic test_stall;
        imem_ack = 1'b1; imem_data = 16'hE000; stall = 1'b1;
        cyc();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1 || b_out !== 2'b11 || imem_req !== 1'b0 || instr !== 16'hE000) begin
                failures++; $display("FAIL stall_hold got=%0h/%b/%0h/%h want=1/11/0/e000", instr_valid, b_out, imem_req, instr);
            end
            if (i < 4) cyc();
        end
        stall = 1'b0;
        cyc();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h5124) begin
            failures++; $display("FAIL stall_resume got=%0h/%0h/%h want=0/1/5124", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_fetch;
        // issued_pc is 0x5123: branch +0x10 lands on 0x5134.
        redirect = 1'b1; redirect_kind = 1'b0; imm = 16'h0010;
        cyc();
        clear_inputs();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h5124) begin failures++; $display("FAIL rf_hold_addr got=%0h/%h want=1/5124", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = 16'hBEEF;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h5134) begin failures++; $display("FAIL rf_early got=%0h/%h want=0/5134", instr_valid, imem_addr); end
        redirect = 1'b1; redirect_kind = 1'b1; imm = 16'h0ABC; imem_ack = 1'b1; imem_data = 16'hBEEF;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h5ABC) begin failures++; $display("FAIL rf_coincident got=%0h/%h want=0/5abc", instr_valid, imem_addr); end
        redirect = 1'b1; redirect_kind = 1'b1; imm = 16'h0111;
        cyc();
        imm = 16'h0222;
        cyc();
        clear_inputs();
        imem_ack = 1'b1;
        cyc();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h5222) begin failures++; $display("FAIL rf_last_wins got=%0h/%h want=0/5222", instr_valid, imem_addr); end
    endtask

    task automatic test_reset_flush;
        redirect = 1'b1; redirect_kind = 1'b1; imm = 16'h0333;
        cyc();
        clear_inputs();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_flush_req got=%0h want=0", imem_req); end
        cyc();
        checks++; if (instr_valid !== 1'b0 || pc !== 16'h0000 || b_out !== 2'b11) begin failures++; $display("FAIL rst_flush_state got=%0h/%h/%b want=0/0000/11", instr_valid, pc, b_out); end
`ifdef CUPS_FETCH_PERF_EN
        checks++; if ({fetch_count, flush_count} !== 32'd0) begin failures++; $display("FAIL rst_flush_counters got=%h want=0", {fetch_count, flush_count}); end
`endif
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_flush_refetch got=%0h/%h want=1/0000", imem_req, imem_addr); end
        // First redirect after reset uses issued_pc = RESET_PC: 0 + 1 + 5.
        redirect = 1'b1; redirect_kind = 1'b0; imm = 16'h0005;
        cyc();
        clear_inputs();
        imem_ack = 1'b1;
        cyc();
        clear_inputs();
        checks++; if (imem_addr !== 16'h0006) begin failures++; $display("FAIL rst_first_redirect got=%h want=0006", imem_addr); end
    endtask

    task automatic test_random;
        logic        have;
        logic        disc;
        logic [15:0] hold_w, hold_pc, faddr, pend, last;
        logic        r_ack, r_stall, r_red, r_kind;
        logic [15:0] r_data, r_imm, tgt;
        int          n_fetch, n_flush;
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        have = 1'b0; disc = 1'b0;
        hold_w = 16'h0; hold_pc = 16'h0; faddr = 16'h0; pend = 16'h0; last = 16'h0;
        n_fetch = 0; n_flush = 0;
        for (int c = 0; c < 800; c++) begin
            checks++; if (imem_req !== !have) begin failures++; $display("FAIL rnd_req c=%0d got=%0h want=%0h", c, imem_req, !have); end
            if (!have) begin
                checks++; if (imem_addr !== faddr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr, faddr); end
            end
            checks++; if (instr_valid !== have) begin failures++; $display("FAIL rnd_valid c=%0d got=%0h want=%0h", c, instr_valid, have); end
            if (have) begin
                checks++; if (instr !== hold_w || pc !== hold_pc) begin failures++; $display("FAIL rnd_instr c=%0d got=%h@%h want=%h@%h", c, instr, pc, hold_w, hold_pc); end
                checks++; if (b_out !== exp_b(hold_w)) begin failures++; $display("FAIL rnd_B c=%0d got=%b want=%b", c, b_out, exp_b(hold_w)); end
                checks++; if (tb !== hold_w[3:0] || tc !== hold_w[7:0] || td !== hold_w[11:0] || sz !== hold_w[12]) begin
                    failures++; $display("FAIL rnd_fields c=%0d got=%h/%h/%h/%0h word=%h", c, tb, tc, td, sz, hold_w);
                end
            end
`ifdef CUPS_FETCH_PERF_EN
            checks++; if (fetch_count !== 16'(n_fetch) || flush_count !== 16'(n_flush)) begin
                failures++; $display("FAIL rnd_counters c=%0d got=%0d/%0d want=%0d/%0d", c, fetch_count, flush_count, n_fetch, n_flush);
            end
`endif
            r_ack   = !have && ($urandom_range(0, 2) == 0);
            r_data  = 16'($urandom);
            r_stall = ($urandom_range(0, 1) == 1);
            r_red   = ($urandom_range(0, 99) < 15);
            r_kind  = ($urandom_range(0, 1) == 1);
            r_imm   = 16'($urandom);
            imem_ack = r_ack; imem_data = r_data; stall = r_stall;
            redirect = r_red; redirect_kind = r_kind; imm = r_imm;
            tgt = r_kind ? {last[15:12], r_imm[11:0]} : 16'(last + 16'd1 + r_imm);
            if (r_red) n_flush = (n_flush < 65535) ? n_flush + 1 : n_flush;
            if (have) begin
                if (r_red) begin
                    have = 1'b0; faddr = tgt;
                end else if (!r_stall) begin
                    have = 1'b0; last = hold_pc;
                    n_fetch = (n_fetch < 65535) ? n_fetch + 1 : n_fetch;
                end
            end else if (r_red) begin
                if (r_ack) begin
                    faddr = tgt; disc = 1'b0;
                end else begin
                    disc = 1'b1; pend = tgt;
                end
            end else if (r_ack) begin
                if (disc) begin
                    faddr = pend; disc = 1'b0;
                end else begin
                    have = 1'b1; hold_w = r_data; hold_pc = faddr; faddr = faddr + 16'd1;
                end
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_branch();
        test_jump();
        test_stall();
        test_redirect_fetch();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction fetch and field-split stage of the 16-bit core, directly upstream of the immediate generator.
- Owns the PC and runs a req/ack read handshake to instruction memory.
- Holds the fetched word, splits it into the immediate fields (tb, tc, td) and the type selector B/sz that drive the immediate generator.
- Takes the generator's sign-extended 16-bit immediate back to redirect the PC on taken branches and jumps.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetched word (word-addressed memory).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  16  fetch address.
- imem_ack  input  1  memory read completion; imem_data valid this cycle.
- imem_data  input  16  fetched instruction word.
- stall  input  1  downstream cannot accept the held instruction.
- redirect  input  1  one-cycle pulse: the last consumed instruction is a taken branch or jump.
- redirect_kind  input  1  0 = branch (relative), 1 = jump.
- imm  input  16  extended immediate from the immediate generator.
- instr_valid  output  1  instr and the decoded fields are valid.
- instr  output  16  held instruction word.
- pc  output  16  address of the held instruction.
- tb  output  4  instr[3:0].
- tc  output  8  instr[7:0].
- td  output  12  instr[11:0].
- B  output  2  immediate type selector.
- sz  output  1  instr[12].

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- States:
  - FETCH: wait for the memory ack.
  - HOLD: present the instruction downstream.
  - FLUSH: wait for the ack of a request being discarded.
- Reset values:
  - state = FETCH, PC register = RESET_PC, issued_pc = RESET_PC.
  - imem_req = 0 in the reset cycle; it asserts in the first cycle after reset deasserts.
  - instr = 0, pc = RESET_PC, instr_valid = 0.
  - B = 2'b11 and all fields are 0 (fields come from instr).
  - Reset mid-handshake abandons the outstanding request. Memory must tolerate a dropped req.
- Handshake rule: once imem_req is high, imem_addr is held stable and req stays high until imem_ack. There is at most one outstanding request.
- FETCH:
  - imem_req = 1, imem_addr = PC.
  - On imem_ack: instr <= imem_data; pc output <= PC; PC <= PC + PC_STEP (mod 2^16); instr_valid <= 1; go to HOLD.
  - Fetch latency is 1 cycle plus memory wait; instr_valid rises in the cycle after the ack.
- HOLD:
  - imem_req = 0.
  - The instruction is consumed in any cycle with instr_valid = 1 and stall = 0. On consume: issued_pc <= pc; instr_valid <= 0; go to FETCH.
  - Throughput is at most one instruction every 2 cycles.
- B decode from instr[15:12]:
  - 0xxx → 2'b00 (type B, 4-bit immediate).
  - 10xx → 2'b01 (type C, branch).
  - 1100 → 2'b10 (type D, jump).
  - anything else → 2'b11 (no immediate).
- Redirect target:
  - Branch: issued_pc + 1 + imm, 16-bit wrap, imm treated as two's complement.
  - Jump: {issued_pc[15:12], imm[11:0]}; imm[15:12] is ignored.
- Redirect in HOLD: PC <= target; instr_valid <= 0 (the held instruction is squashed, not consumed); go to FETCH. Redirect takes priority over a simultaneous consume.
- Redirect in FETCH, no ack in the same cycle: latch target into PC_pending and go to FLUSH. imem_req and imem_addr stay unchanged.
- Redirect in FETCH with ack in the same cycle: discard imem_data; PC <= target; stay in FETCH; issue the new request next cycle.
- FLUSH:
  - imem_req = 1 with the old address.
  - On ack: discard the data, PC <= PC_pending, go to FETCH.
  - A further redirect while in FLUSH overwrites PC_pending; the last redirect wins.
- Redirect while instr_valid = 0 and state = FETCH after reset: accepted as normal, using issued_pc.

Optional Feature:
- Macro: CUPS_FETCH_PERF_EN.
- When defined, the block adds two outputs:
  - fetch_count [15:0]: increments on each consumed instruction.
  - flush_count [15:0]: increments on each redirect accepted.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, memory acks after 2 wait cycles with 16'h1234, stall = 0 → imem_addr = 0x0000; instr = 0x1234, B = 00, tb = 4, instr_valid for 1 cycle; next imem_addr = 0x0001.
- Held word 16'h8AF0 (B = 01, tc = F0), consumed at pc 0x0010, then redirect_kind = 0 with imm = 16'hFFF0 → next imem_addr = 0x0001.
- Held word 16'hC123 (B = 10, td = 123) at pc 0x5000, consumed, then jump with imm = 16'hF123 → next imem_addr = 0x5123.
- stall held high 5 cycles with word 16'hE000 → instr_valid stays 1, B = 11, no imem_req; fetch resumes 1 cycle after stall drops.
- Redirect asserted during FETCH 1 cycle before the ack → data from the old address discarded, instr_valid stays 0, next request goes to the target; redirect coincident with the ack gives the same result.
- Reset asserted in FLUSH with req outstanding → next cycle imem_req = 0, instr_valid = 0, then fetch from RESET_PC; with CUPS_FETCH_PERF_EN both counters read 0.
